// File: rtl/nrisc_mux_arbiter_pkg.sv
// rtl/nrisc_mux_arbiter_pkg.sv - shared constants, types and helpers for the mux arbiter
package nrisc_mux_arbiter_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [SEL_W-1:0] sel_t;

  function automatic req_vec_t onehot(input sel_t idx);
    req_vec_t v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/nrisc_mux_arbiter_if.sv
// rtl/nrisc_mux_arbiter_if.sv - request/grant bundle between requesters and the mux arbiter
interface nrisc_mux_arbiter_if;
  import nrisc_mux_arbiter_pkg::*;

  req_vec_t ARB_req;
  req_vec_t ARB_gnt;
  sel_t     ARB_sel;
  logic     ARB_valid;
  logic     ARB_preempt;

  modport master (
    output ARB_req,
    input  ARB_gnt,
    input  ARB_sel,
    input  ARB_valid,
    input  ARB_preempt
  );

  modport slave (
    input  ARB_req,
    output ARB_gnt,
    output ARB_sel,
    output ARB_valid,
    output ARB_preempt
  );

endinterface

// File: rtl/nrisc_mux_arbiter_rr_pick.sv
// rtl/nrisc_mux_arbiter_rr_pick.sv - combinational round-robin priority find starting at ptr
module nrisc_rr_pick
  import nrisc_mux_arbiter_pkg::*;
(
  input  req_vec_t req,
  input  sel_t     ptr,
  output logic     any,
  output sel_t     idx
);

  sel_t cand;

  // Scan from the farthest offset down so the nearest set bit to ptr is written last.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/nrisc_mux_arbiter.sv
// rtl/nrisc_mux_arbiter.sv - round-robin owner arbiter for the shared 16:1 datapath mux
// Break-before-make: every ownership change passes through one dead TURN cycle.
module nrisc_mux_arbiter
  import nrisc_mux_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nrisc_mux_arbiter_if.slave    arb
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [1:0]       state;
  sel_t             ptr;
  logic [CNT_W-1:0] hold_cnt;
  req_vec_t         gnt_q;
  sel_t             sel_q;
  logic             valid_q;
  logic             preempt_q;

  logic pick_any;
  sel_t pick_idx;
  logic owner_req;
  logic others_pending;
  logic hold_expired;

  nrisc_rr_pick u_pick (
    .req (arb.ARB_req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign owner_req      = arb.ARB_req[sel_q];
  assign others_pending = |(arb.ARB_req & ~gnt_q);
  assign hold_expired   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state)
        ST_IDLE, ST_TURN: begin
          if (pick_any) begin
            state    <= ST_GRANT;
            gnt_q    <= onehot(pick_idx);
            sel_q    <= pick_idx;
            valid_q  <= 1'b1;
            hold_cnt <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          // An owner release wins over a coincident hold expiry, so no preempt pulse then.
          if (!owner_req || (others_pending && hold_expired)) begin
            state     <= ST_TURN;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            ptr       <= sel_q + SEL_W'(1);
            hold_cnt  <= '0;
            preempt_q <= owner_req;
          end else if (others_pending) begin
            if (hold_cnt != CNT_MAX) hold_cnt <= hold_cnt + CNT_W'(1);
          end else begin
            hold_cnt <= '0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          ptr       <= '0;
          hold_cnt  <= '0;
          gnt_q     <= '0;
          sel_q     <= '0;
          valid_q   <= 1'b0;
          preempt_q <= 1'b0;
        end
      endcase
    end
  end

  assign arb.ARB_gnt     = gnt_q;
  assign arb.ARB_sel     = sel_q;
  assign arb.ARB_valid   = valid_q;
  assign arb.ARB_preempt = preempt_q;

endmodule

// File: tb/tb_nrisc_mux_arbiter.sv
// tb/tb_nrisc_mux_arbiter.sv - directed self-checking bench for nrisc_mux_arbiter
`timescale 1ns/1ps
module tb_nrisc_mux_arbiter;
  import nrisc_mux_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  nrisc_mux_arbiter_if arb_if();

  nrisc_mux_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input logic [15:0] g, input logic [3:0] s);
    check({tag, " gnt"}, 32'(arb_if.ARB_gnt), 32'(g));
    check({tag, " sel"}, 32'(arb_if.ARB_sel), 32'(s));
    check({tag, " valid"}, 32'(arb_if.ARB_valid), 32'(g != 16'h0));
  endtask

  initial begin
    logic [15:0] exp_g;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    arb_if.ARB_req = 16'h0;
    step();
    step();
    expect_grant("reset", 16'h0000, 4'd0);
    check("reset preempt", 32'(arb_if.ARB_preempt), 32'd0);
    rst_n = 1'b1;

    // basic grant, drop, turnaround
    arb_if.ARB_req = 16'h0008;
    step();
    expect_grant("basic", 16'h0008, 4'd3);
    arb_if.ARB_req = 16'h0000;
    step();
    expect_grant("basic turn", 16'h0000, 4'd3);
    step();
    expect_grant("basic idle", 16'h0000, 4'd3);

    // async reset mid-grant
    arb_if.ARB_req = 16'h0020;
    step();
    expect_grant("pre-reset", 16'h0020, 4'd5);
    #3 rst_n = 1'b0;
    #1;
    expect_grant("async reset", 16'h0000, 4'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    expect_grant("post-reset", 16'h0020, 4'd5);
    arb_if.ARB_req = 16'h0000;
    step();
    step();

    // serve 15 alone so ptr wraps to 0
    arb_if.ARB_req = 16'h8000;
    step();
    expect_grant("wrap15", 16'h8000, 4'd15);
    arb_if.ARB_req = 16'h0000;
    step();
    expect_grant("wrap15 turn", 16'h0000, 4'd15);

    // full round-robin sweep, one TURN between grants
    arb_if.ARB_req = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      exp_g = 16'h0001 << (k % 16);
      step();
      expect_grant($sformatf("rr%0d", k), exp_g, 4'(k % 16));
      arb_if.ARB_req = 16'hFFFF & ~exp_g;
      step();
      check($sformatf("rr%0d turn gnt", k), 32'(arb_if.ARB_gnt), 32'd0);
      arb_if.ARB_req = 16'hFFFF;
    end
    arb_if.ARB_req = 16'h0000;
    step();
    step();

    // ptr=15 after serving 14, then 0x8001 -> 15 then 0
    arb_if.ARB_req = 16'h4000;
    step();
    expect_grant("t4 14", 16'h4000, 4'd14);
    arb_if.ARB_req = 16'h0000;
    step();
    arb_if.ARB_req = 16'h8001;
    step();
    expect_grant("t4 first", 16'h8000, 4'd15);
    arb_if.ARB_req = 16'h0001;
    step();
    expect_grant("t4 turn", 16'h0000, 4'd15);
    step();
    expect_grant("t4 second", 16'h0001, 4'd0);
    arb_if.ARB_req = 16'h0000;
    step();
    step();

    // preemption: owner 0 held, 7 arrives
    arb_if.ARB_req = 16'h0001;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      expect_grant("t5 alone", 16'h0001, 4'd0);
    end
    arb_if.ARB_req = 16'h0081;
    for (int i = 0; i < 7; i++) begin
      step();
      expect_grant($sformatf("t5 hold%0d", i), 16'h0001, 4'd0);
      check("t5 hold preempt", 32'(arb_if.ARB_preempt), 32'd0);
    end
    step();
    expect_grant("t5 preempt turn", 16'h0000, 4'd0);
    check("t5 preempt pulse", 32'(arb_if.ARB_preempt), 32'd1);
    step();
    expect_grant("t5 new owner", 16'h0080, 4'd7);
    check("t5 pulse width", 32'(arb_if.ARB_preempt), 32'd0);
    for (int i = 0; i < 7; i++) step();
    expect_grant("t5 owner7 hold", 16'h0080, 4'd7);
    step();
    check("t5 second preempt", 32'(arb_if.ARB_preempt), 32'd1);
    step();
    expect_grant("t5 back to 0", 16'h0001, 4'd0);

    // owner drop coincides with hold expiry: plain drop
    for (int i = 0; i < 7; i++) step();
    expect_grant("t5 coincide hold", 16'h0001, 4'd0);
    arb_if.ARB_req = 16'h0080;
    step();
    expect_grant("t5 coincide turn", 16'h0000, 4'd0);
    check("t5 coincide preempt", 32'(arb_if.ARB_preempt), 32'd0);
    step();
    expect_grant("t5 coincide next", 16'h0080, 4'd7);
    arb_if.ARB_req = 16'h0000;
    step();
    step();

    // long uncontended hold never preempts
    arb_if.ARB_req = 16'h0004;
    step();
    for (int i = 0; i < 100; i++) begin
      step();
      check("t6 gnt", 32'(arb_if.ARB_gnt), 32'h0004);
      check("t6 preempt", 32'(arb_if.ARB_preempt), 32'd0);
    end

    // hold counter clears once contention disappears
    arb_if.ARB_req = 16'h0014;
    for (int i = 0; i < 5; i++) step();
    arb_if.ARB_req = 16'h0004;
    step();
    arb_if.ARB_req = 16'h0014;
    for (int i = 0; i < 7; i++) begin
      step();
      check("clr hold gnt", 32'(arb_if.ARB_gnt), 32'h0004);
    end
    step();
    check("clr preempt", 32'(arb_if.ARB_preempt), 32'd1);
    step();
    expect_grant("clr next owner", 16'h0010, 4'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
